// File: rtl/vdf_iteration_sequencer.sv
// Sequencer for a VDF repeated-squaring job: launches one squaring per round
// into a fixed-latency datapath, captures the result and counts iterations.
module vdf_iteration_sequencer #(
  parameter int LOGNUMSYMBOLS = 5,
  parameter int LOGRADIX      = 33,
  parameter int PIPE_LATENCY  = 4,
  parameter int ITER_W        = 32,
  localparam int DW           = (1 << LOGNUMSYMBOLS) * (LOGRADIX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DW-1:0]     start_data,
  input  logic [ITER_W-1:0] start_iters,
  input  logic              abort,
  output logic              dp_issue,
  output logic [DW-1:0]     dp_data,
  input  logic [DW-1:0]     dp_result,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [DW-1:0]     done_data,
  output logic [ITER_W-1:0] done_iters,
  output logic              busy
);

  localparam int LAT_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     value_q, value_d;
  logic [ITER_W-1:0] remaining_q, remaining_d;
  logic [ITER_W-1:0] completed_q, completed_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              dp_issue_q, dp_issue_d;
  logic              done_valid_q, done_valid_d;
  logic              busy_q, busy_d;
  logic              start_ready_q, start_ready_d;

  // Next-state, datapath bookkeeping and registered-output decode
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    completed_d = completed_q;
    lat_d       = lat_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          value_d     = start_data;
          remaining_d = start_iters;
          completed_d = {ITER_W{1'b0}};
          lat_d       = {LAT_W{1'b0}};
          state_d     = (start_iters != {ITER_W{1'b0}}) ? ISSUE : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          lat_d   = {LAT_W{1'b0}};
          state_d = WAIT;
        end
      end
      WAIT: begin
        // abort wins over a capture landing in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          value_d     = dp_result;
          remaining_d = remaining_q - ITER_W'(1);
          completed_d = completed_q + ITER_W'(1);
          state_d     = (remaining_q == ITER_W'(1)) ? DONE : ISSUE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dp_issue_d    = (state_d == ISSUE);
    done_valid_d  = (state_d == DONE);
    busy_d        = (state_d != IDLE);
    start_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      value_q       <= {DW{1'b0}};
      remaining_q   <= {ITER_W{1'b0}};
      completed_q   <= {ITER_W{1'b0}};
      lat_q         <= {LAT_W{1'b0}};
      dp_issue_q    <= 1'b0;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      remaining_q   <= remaining_d;
      completed_q   <= completed_d;
      lat_q         <= lat_d;
      dp_issue_q    <= dp_issue_d;
      done_valid_q  <= done_valid_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign dp_issue    = dp_issue_q;
  assign dp_data     = value_q;
  assign done_valid  = done_valid_q;
  assign done_data   = value_q;
  assign done_iters  = completed_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vdf_iteration_sequencer.sv
// Self-checking bench: fixed-latency datapath model, table of jobs with a
// result scoreboard, plus hand-written abort / reset / hold sequences.
module tb_vdf_iteration_sequencer;

  localparam int LNS    = 5;
  localparam int LR     = 33;
  localparam int PL     = 4;
  localparam int ITER_W = 32;
  localparam int DW     = (1 << LNS) * (LR + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [DW-1:0]     start_data;
  logic [ITER_W-1:0] start_iters;
  logic              abort;
  logic              dp_issue;
  logic [DW-1:0]     dp_data;
  logic [DW-1:0]     dp_result;
  logic              done_valid;
  logic              done_ready;
  logic [DW-1:0]     done_data;
  logic [ITER_W-1:0] done_iters;
  logic              busy;

  vdf_iteration_sequencer #(
    .LOGNUMSYMBOLS(LNS), .LOGRADIX(LR), .PIPE_LATENCY(PL), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_data(start_data), .start_iters(start_iters),
    .abort(abort),
    .dp_issue(dp_issue), .dp_data(dp_data), .dp_result(dp_result),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_data(done_data), .done_iters(done_iters),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: mode 0 is x+1, mode 1 a full-width mixing function
  bit mode = 1'b0;
  function automatic logic [DW-1:0] dp_f(input logic [DW-1:0] x, input bit m);
    if (m == 1'b0) return x + DW'(1);
    return {x[DW-2:0], x[DW-1]} + (x >> 7);
  endfunction

  logic [DW-1:0] pipe [PL];
  always @(posedge clk) begin
    pipe[0] <= dp_issue ? dp_f(dp_data, mode) : {DW{1'b0}};
    for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_result = pipe[PL-1];

  int issue_q[$];
  always @(negedge clk) if (dp_issue) issue_q.push_back(cyc);

  typedef struct {
    logic [DW-1:0]     data;
    logic [ITER_W-1:0] iters;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic run_job(input logic [DW-1:0] data, input logic [ITER_W-1:0] iters,
                         input logic [DW-1:0] exp_data, input int hold, input bit start_abort);
    exp_t e;
    int t0;
    bit got;
    logic [DW-1:0] hd;
    logic [ITER_W-1:0] hi;
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    issue_q.delete();
    start_valid = 1'b1; start_data = data; start_iters = iters; abort = start_abort;
    t0 = cyc;
    sb.push_back('{exp_data, iters});
    @(negedge clk);
    start_valid = 1'b0; abort = 1'b0; start_data = '0;
    got = 1'b0;
    while (cyc <= t0 + 1 + int'(iters) * (PL + 1) + 20) begin
      if (done_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done_valid expected done at +%0d", 1 + int'(iters) * (PL + 1));
      void'(sb.pop_front());
      return;
    end
    chk("done_latency", cyc - t0, 1 + int'(iters) * (PL + 1));
    e = sb.pop_front();
    chk("done_data", done_data, e.data);
    chk("done_iters", done_iters, e.iters);
    chk("busy_done", busy, 1);
    chk("start_ready_done", start_ready, 0);
    hd = done_data; hi = done_iters;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", done_valid, 1);
      chk("hold_data", done_data, hd);
      chk("hold_iters", done_iters, hi);
      chk("hold_start_ready", start_ready, 0);
      start_valid = (k == 3);
      start_data  = ~data;
      abort       = (k == 5);
    end
    start_valid = 1'b0; abort = 1'b0; start_data = '0;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk("post_done_valid", done_valid, 0);
    chk("post_start_ready", start_ready, 1);
    chk("post_busy", busy, 0);
    chk("issue_count", issue_q.size(), iters);
    foreach (issue_q[k]) chk("issue_cycle", issue_q[k] - t0, 1 + k * (PL + 1));
  endtask

  typedef struct {
    logic [DW-1:0]     data;
    logic [ITER_W-1:0] iters;
    logic [DW-1:0]     exp;
    int                hold;
    bit                sab;
  } vec_t;
  vec_t vt[5];

  initial begin
    int t0, extra;
    logic [DW-1:0] rnd, gold;

    vt[0] = '{DW'(5),     32'd3, DW'(8),     0,  1'b0};
    vt[1] = '{DW'('hABC), 32'd0, DW'('hABC), 0,  1'b0};
    vt[2] = '{DW'(100),   32'd5, DW'(105),   0,  1'b1};
    vt[3] = '{'1,         32'd1, '0,         0,  1'b0};
    vt[4] = '{DW'(3),     32'd2, DW'(5),     10, 1'b0};

    rst = 1'b1; start_valid = 1'b0; start_data = '0; start_iters = '0;
    abort = 1'b0; done_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dp_issue", dp_issue, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_done_data", done_data, 0);
    chk("rst_done_iters", done_iters, 0);

    for (int i = 0; i < 5; i++) run_job(vt[i].data, vt[i].iters, vt[i].exp, vt[i].hold, vt[i].sab);

    // Abort in WAIT of a 3-iteration job
    @(negedge clk);
    issue_q.delete();
    start_valid = 1'b1; start_data = DW'(5); start_iters = 32'd3; t0 = cyc;
    @(negedge clk);
    start_valid = 1'b0;
    while (cyc < t0 + 8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_start_ready", start_ready, 1);
    chk("abort_done_valid", done_valid, 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (dp_issue || done_valid) extra++;
    end
    chk("abort_quiet", extra, 0);
    chk("abort_issue_count", issue_q.size(), 2);
    run_job(DW'(20), 32'd2, DW'(22), 0, 1'b0);

    // Reset in the middle of WAIT
    @(negedge clk);
    start_valid = 1'b1; start_data = DW'(9); start_iters = 32'd2; t0 = cyc;
    @(negedge clk);
    start_valid = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_dp_issue", dp_issue, 0);
    chk("midrst_done_valid", done_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_start_ready", start_ready, 1);
    chk("midrst_done_data", done_data, 0);
    chk("midrst_done_iters", done_iters, 0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (dp_issue || done_valid) extra++;
    end
    chk("midrst_quiet", extra, 0);
    run_job(DW'(7), 32'd1, DW'(8), 0, 1'b0);

    // Full-width random operand against the golden model
    mode = 1'b1;
    for (int k = 0; k < DW / 32; k++) rnd[k*32 +: 32] = $urandom;
    gold = rnd;
    for (int k = 0; k < 4; k++) gold = dp_f(gold, 1'b1);
    run_job(rnd, 32'd4, gold, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
